// File: rtl/spi_bus_pkg.sv
// Shared constants, FSM state type and frame helper for the SPI bus bridge.
// Optional RAM mode-register init frame is enabled by SPI_RAM_MODE_INIT_EN.
package spi_bus_pkg;

  localparam logic [7:0] SPI_OP_READ      = 8'h03;
  localparam logic [7:0] SPI_OP_WRITE     = 8'h02;
  localparam logic [7:0] SPI_OP_WRMR      = 8'h01;
  localparam logic [7:0] SPI_RAM_MODE_SEQ = 8'h40;

  localparam int FRAME_BITS = 40;
  localparam int INIT_BITS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SHIFT,
    ST_DESELECT,
    ST_DONE
  } state_t;

  // Opcode, 24-bit address (upper 9 bits zero), then the data byte.
  function automatic logic [39:0] build_frame(input logic [7:0] op,
                                              input logic [14:0] addr,
                                              input logic [7:0] data);
    return {op, 9'b0, addr, data};
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// Mode-0 SPI shift engine: 40-bit MSB-first shift register, SCK at clk/2,
// rising-edge counter and an 8-bit capture of the last bits seen on MISO.
module spi_shifter
  import spi_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        start,
  input  logic [39:0] frame,
  input  logic [5:0]  last_bit,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        busy,
  output logic [7:0]  rx_byte
);

  logic [39:0] shreg;
  logic [5:0]  bit_cnt;
  logic [5:0]  last_q;

  // MOSI is the register MSB, so it only moves on the edge that drops SCK.
  assign mosi = shreg[39];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the block order cannot create races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      last_q  <= '0;
      sck     <= 1'b0;
      busy    <= 1'b0;
      rx_byte <= '0;
    end else if (load) begin
      shreg  <= frame;
      last_q <= last_bit;
    end else if (start) begin
      busy    <= 1'b1;
      sck     <= 1'b1;
      bit_cnt <= '0;
      rx_byte <= {rx_byte[6:0], miso};
    end else if (busy) begin
      if (sck) begin
        sck   <= 1'b0;
        shreg <= {shreg[38:0], 1'b0};
        if (bit_cnt == last_q) busy <= 1'b0;
      end else begin
        sck     <= 1'b1;
        bit_cnt <= bit_cnt + 6'd1;
        rx_byte <= {rx_byte[6:0], miso};
      end
    end
  end

endmodule

// File: rtl/spi_bus_bridge.sv
// CPU byte bus to SPI flash/RAM bridge; one SPI frame per bus access.
// Define SPI_RAM_MODE_INIT_EN to send the RAM a sequential-mode frame after reset.
module spi_bus_bridge
  import spi_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_address_out,
  input  logic [7:0]  bus_data_out,
  output logic [7:0]  bus_data_in,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic        bus_wait,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        flash_ce_n,
  output logic        ram_ce_n
);

  state_t      state;
  logic        req;
  logic        flash_write;
  logic        load;
  logic        start;
  logic        busy;
  logic        op_read;
  logic        abandon;
  logic        init_active;
  logic [39:0] frame;
  logic [5:0]  last_bit;
  logic [7:0]  rx_byte;

  assign req         = bus_read | bus_write;
  assign flash_write = bus_write && !bus_read && !bus_address_out[15];
  assign bus_wait    = req && !(state == ST_DONE && !init_active);
  assign load        = (state == ST_IDLE) && (init_active || (req && !flash_write));
  assign start       = (state == ST_SELECT);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    frame    = build_frame(bus_read ? SPI_OP_READ : SPI_OP_WRITE,
                           bus_address_out[14:0],
                           bus_read ? 8'h00 : bus_data_out);
    last_bit = 6'(FRAME_BITS - 1);
    if (init_active) begin
      frame    = {SPI_OP_WRMR, SPI_RAM_MODE_SEQ, 24'h0};
      last_bit = 6'(INIT_BITS - 1);
    end
  end

`ifndef SPI_RAM_MODE_INIT_EN
  assign init_active = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      flash_ce_n  <= 1'b1;
      ram_ce_n    <= 1'b1;
      bus_data_in <= 8'h00;
      op_read     <= 1'b0;
      abandon     <= 1'b0;
`ifdef SPI_RAM_MODE_INIT_EN
      init_active <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (init_active) begin
            ram_ce_n <= 1'b0;
            op_read  <= 1'b0;
            abandon  <= 1'b0;
            state    <= ST_SELECT;
          end else if (flash_write) begin
            // Flash is read-only: acknowledge without touching the pins.
            state <= ST_DONE;
          end else if (req) begin
            op_read <= bus_read;
            abandon <= 1'b0;
            if (bus_address_out[15]) ram_ce_n <= 1'b0;
            else                     flash_ce_n <= 1'b0;
            state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (!req) abandon <= 1'b1;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!req) abandon <= 1'b1;
          if (!busy) begin
            flash_ce_n <= 1'b1;
            ram_ce_n   <= 1'b1;
            state      <= ST_DESELECT;
          end
        end
        ST_DESELECT: begin
          // A read whose request went away mid-frame leaves the old data.
          if (op_read && !abandon && req) bus_data_in <= rx_byte;
          state <= ST_DONE;
        end
        ST_DONE: begin
`ifdef SPI_RAM_MODE_INIT_EN
          init_active <= 1'b0;
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .start    (start),
    .frame    (frame),
    .last_bit (last_bit),
    .miso     (spi_miso),
    .sck      (spi_clk),
    .mosi     (spi_mosi),
    .busy     (busy),
    .rx_byte  (rx_byte)
  );

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Scoreboard bench for spi_bus_bridge with behavioural SPI flash/RAM devices.
module tb_spi_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus_address_out = '0;
  logic [7:0]  bus_data_out = '0;
  logic [7:0]  bus_data_in;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic        bus_wait;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        flash_ce_n;
  logic        ram_ce_n;

  always #5 clk = ~clk;

  spi_bus_bridge dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_address_out (bus_address_out),
    .bus_data_out    (bus_data_out),
    .bus_data_in     (bus_data_in),
    .bus_read        (bus_read),
    .bus_write       (bus_write),
    .bus_wait        (bus_wait),
    .spi_clk         (spi_clk),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso),
    .flash_ce_n      (flash_ce_n),
    .ram_ce_n        (ram_ce_n)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  typedef struct {
    bit          rd;
    logic [7:0]  data;
    int          lat;
    bit          has_frame;
    bit          ram;
    logic [39:0] frame;
  } exp_t;

  typedef struct {
    bit          ram;
    int          nbits;
    logic [39:0] bits;
    int          lowc;
  } frame_t;

  exp_t   exp_q[$];
  frame_t frm_q[$];

  // Reference model memories and the value bus_data_in should be holding.
  bit [7:0]   ref_flash [32768];
  bit [7:0]   ref_ram   [32768];
  logic [7:0] last_read = 8'h00;

  // ---------------- behavioural SPI devices ----------------
  bit [7:0]    dev_flash [32768];
  bit [7:0]    dev_ram   [32768];
  logic [39:0] dv_bits = '0;
  int          dv_n = 0;
  bit          dv_ram = 1'b0;
  logic [14:0] dv_addr = '0;
  logic [7:0]  dv_op = '0;
  logic [7:0]  dv_byte;

  always @(negedge flash_ce_n) begin dv_n = 0; dv_ram = 1'b0; end
  always @(negedge ram_ce_n)   begin dv_n = 0; dv_ram = 1'b1; end

  always @(posedge spi_clk) begin
    if (flash_ce_n === 1'b0 || ram_ce_n === 1'b0) begin
      dv_bits = {dv_bits[38:0], spi_mosi};
      dv_n++;
      if (dv_n == 8)  dv_op = dv_bits[7:0];
      if (dv_n == 32) dv_addr = dv_bits[14:0];
      if (dv_n == 40 && dv_ram && dv_bits[39:32] == 8'h02) dev_ram[dv_bits[22:8]] = dv_bits[7:0];
    end
  end

  always @(negedge spi_clk) begin
    if ((flash_ce_n === 1'b0 || ram_ce_n === 1'b0) && dv_op == 8'h03 && dv_n >= 32 && dv_n < 40) begin
      dv_byte  = dv_ram ? dev_ram[dv_addr] : dev_flash[dv_addr];
      spi_miso = dv_byte[39 - dv_n];
    end else begin
      spi_miso = 1'b0;
    end
  end

  // ---------------- chip-enable / frame monitor ----------------
  logic prev_f = 1'b1;
  logic prev_r = 1'b1;
  int   lowc = 0;
  int   sck_viol = 0;
  int   both_viol = 0;

  always @(negedge clk) begin
    if ((flash_ce_n !== prev_f || ram_ce_n !== prev_r) && spi_clk !== 1'b0) sck_viol++;
    if (flash_ce_n === 1'b0 && ram_ce_n === 1'b0) both_viol++;
    if (flash_ce_n === 1'b0 || ram_ce_n === 1'b0) lowc++;
    else if (prev_f === 1'b0 || prev_r === 1'b0) begin
      frm_q.push_back('{ram: dv_ram, nbits: dv_n, bits: dv_bits, lowc: lowc});
      lowc = 0;
    end
    prev_f = flash_ce_n;
    prev_r = ram_ce_n;
  end

  // ---------------- scoreboard monitor ----------------
  bit     abort_mode = 1'b0;
  bit     active = 1'b0;
  int     count = 0;
  int     done_cnt = 0;
  exp_t   mon_e;
  frame_t mon_f;

  always @(negedge clk) begin
    if (!rst_n || abort_mode) begin
      active = 1'b0;
    end else begin
      if (!active && (bus_read || bus_write)) begin
        active = 1'b1;
        count  = 0;
      end else if (active) begin
        count++;
      end
      if (active && !bus_wait) begin
        check("exp_available", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("latency", count, mon_e.lat);
          check("bus_data_in", bus_data_in, mon_e.data);
          if (mon_e.has_frame) begin
            check("frame_present", frm_q.size() != 0, 1);
            if (frm_q.size() != 0) begin
              mon_f = frm_q.pop_front();
              check("frame_bits", mon_f.bits, mon_e.frame);
              check("frame_sck_edges", mon_f.nbits, 40);
              check("frame_device", mon_f.ram, mon_e.ram);
              check("ce_low_cycles", mon_f.lowc, 81);
            end
          end else begin
            check("no_spi_frame", frm_q.size(), 0);
          end
        end
        active = 1'b0;
        done_cnt++;
      end else if (active && count > 300) begin
        check("done_within_budget", count <= 300, 1);
        if (exp_q.size() != 0) mon_e = exp_q.pop_front();
        active = 1'b0;
        done_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic preload_flash(input logic [14:0] a, input logic [7:0] v);
    ref_flash[a] = v;
    dev_flash[a] = v;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.rd  = rd;
    e.ram = a[15];
    if (rd) begin
      e.data      = a[15] ? ref_ram[a[14:0]] : ref_flash[a[14:0]];
      last_read   = e.data;
      e.lat       = 83;
      e.has_frame = 1'b1;
      e.frame     = {8'h03, 9'h0, a[14:0], 8'h00};
    end else if (a[15]) begin
      ref_ram[a[14:0]] = d;
      e.data      = last_read;
      e.lat       = 83;
      e.has_frame = 1'b1;
      e.frame     = {8'h02, 9'h0, a[14:0], d};
    end else begin
      e.data      = last_read;
      e.lat       = 1;
      e.has_frame = 1'b0;
      e.frame     = '0;
    end
    exp_q.push_back(e);
    bus_address_out = a;
    bus_data_out    = d;
    bus_read        = rd;
    bus_write       = wr;
  endtask

  task automatic wait_done(input int prev);
    int g;
    g = 0;
    while (done_cnt == prev && g < 400) begin
      @(posedge clk);
      g++;
    end
    check("done_seen", done_cnt != prev, 1);
    #1;
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
    int prev;
    prev = done_cnt;
    issue(rd, wr, a, d);
    wait_done(prev);
  endtask

  task automatic idle();
    bus_read  = 1'b0;
    bus_write = 1'b0;
  endtask

  initial begin
    int g;
    int kind;
    int gap;
    logic [15:0] a;
    logic [7:0]  d;

    for (int i = 0; i < 32768; i++) preload_flash(15'(i), 8'($urandom));
    preload_flash(15'h0123, 8'h5A);
    preload_flash(15'h0010, 8'h3C);
    preload_flash(15'h0000, 8'hC3);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_flash_ce_n", flash_ce_n, 1);
    check("rst_ram_ce_n", ram_ce_n, 1);
    check("rst_spi_clk", spi_clk, 0);
    check("rst_spi_mosi", spi_mosi, 0);
    check("rst_bus_data_in", bus_data_in, 8'h00);
    check("rst_bus_wait", bus_wait, 0);
    @(posedge clk); #1;

    // Flash read, RAM write/readback, flash write ignored, both-high is a read.
    txn(1'b1, 1'b0, 16'h0123, 8'h00); idle();
    txn(1'b0, 1'b1, 16'h8010, 8'hA5); idle();
    txn(1'b1, 1'b0, 16'h8010, 8'h00); idle();
    txn(1'b0, 1'b1, 16'h0010, 8'h77); idle();
    txn(1'b1, 1'b0, 16'h0010, 8'h00); idle();
    txn(1'b1, 1'b0, 16'h0000, 8'h00);
    txn(1'b1, 1'b0, 16'h8000, 8'h00); idle();
    txn(1'b1, 1'b1, 16'h8010, 8'h11); idle();

    // Reset at the 20th SCK rising edge of a read.
    preload_flash(15'h0042, 8'h96);
    abort_mode = 1'b1;
    bus_address_out = 16'h0042;
    bus_read = 1'b1;
    repeat (3) @(posedge clk);
    g = 0;
    while (dv_n < 20 && g < 200) begin @(posedge clk); g++; end
    check("reached_sck_edge_20", dv_n >= 20, 1);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_flash_ce_n", flash_ce_n, 1);
    check("midrst_ram_ce_n", ram_ce_n, 1);
    check("midrst_spi_clk", spi_clk, 0);
    check("midrst_bus_data_in", bus_data_in, 8'h00);
    last_read = 8'h00;
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    frm_q.delete();
    abort_mode = 1'b0;
    txn(1'b1, 1'b0, 16'h0042, 8'h00); idle();

    // Read dropped mid-frame: frame still completes, data is discarded.
    preload_flash(15'h0200, ~last_read);
    abort_mode = 1'b1;
    bus_address_out = 16'h0200;
    bus_read = 1'b1;
    repeat (10) @(posedge clk);
    #1 idle();
    repeat (100) @(posedge clk);
    #1;
    check("dropped_read_keeps_data", bus_data_in, last_read);
    check("dropped_read_frames", frm_q.size(), 1);
    if (frm_q.size() != 0) check("dropped_read_sck_edges", frm_q[0].nbits, 40);
    frm_q.delete();
    abort_mode = 1'b0;

    // Randomised mix with 0..2 idle cycles between requests.
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      gap  = $urandom_range(0, 2);
      a    = {1'($urandom), 7'h0, 8'($urandom_range(0, 15))};
      d    = 8'($urandom);
      if (gap > 0) begin
        idle();
        repeat (gap) begin @(posedge clk); #1; end
      end
      case (kind)
        0, 3:    txn(1'b1, 1'b0, a, d);
        1:       txn(1'b0, 1'b1, a, d);
        default: txn(1'b1, 1'b1, a, d);
      endcase
    end
    idle();
    repeat (5) @(posedge clk);

    check("exp_queue_drained", exp_q.size(), 0);
    check("frame_queue_drained", frm_q.size(), 0);
    check("sck_low_at_ce_change", sck_viol, 0);
    check("never_both_ce_low", both_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
